// File: rtl/rns2bin_mrc_seq.sv
// Sequential mixed-radix converter for the residue set {32,31,21,5}: one MRC digit per cycle.
// Optional RNS_RANGE_CHECK_EN flags out-of-range tuples instead of canonicalising them.
module rns2bin_mrc_seq #(
    parameter int unsigned MOD_SIZE = 5,
    parameter int unsigned DYN_SIZE = 17,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MOD_SIZE-1:0] x0,
    input  logic [MOD_SIZE-1:0] x1,
    input  logic [MOD_SIZE-1:0] x2,
    input  logic [MOD_SIZE-1:0] x3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DYN_SIZE-1:0] N,
    output logic                out_err,
    output logic                busy,
    output logic [CNT_W-1:0]    conv_cnt
);

    typedef enum logic [2:0] {StIdle, StD2, StD3, StD4, StAcc, StOut} state_e;

    localparam logic [DYN_SIZE-1:0] W2 = DYN_SIZE'(32);
    localparam logic [DYN_SIZE-1:0] W3 = DYN_SIZE'(992);
    localparam logic [DYN_SIZE-1:0] W4 = DYN_SIZE'(20832);

    state_e               state_q, state_d;
    logic [MOD_SIZE-1:0]  x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
    logic [MOD_SIZE-1:0]  a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
    logic [2:0]           a4_q, a4_d;
    logic [DYN_SIZE-1:0]  n_q, n_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [9:0]           t1, t2, t3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            x1_q        <= '0;
            x2_q        <= '0;
            x3_q        <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            a3_q        <= '0;
            a4_q        <= '0;
            n_q         <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            x3_q        <= x3_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            a3_q        <= a3_d;
            a4_q        <= a4_d;
            n_q         <= n_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    // Offsets added before each '%' keep every signed difference non-negative.
    always_comb begin
        state_d     = state_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        x3_d        = x3_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        a3_d        = a3_q;
        a4_d        = a4_q;
        n_d         = n_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        in_ready    = 1'b0;
        t1          = '0;
        t2          = '0;
        t3          = '0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a1_d = x0;
`ifdef RNS_RANGE_CHECK_EN
                    x1_d  = x1;
                    x2_d  = x2;
                    x3_d  = x3;
                    err_d = (x1 == MOD_SIZE'(31)) || (x2 >= MOD_SIZE'(21)) ||
                            (x3 >= MOD_SIZE'(5));
`else
                    x1_d  = (x1 == MOD_SIZE'(31)) ? '0 : x1;
                    x2_d  = (x2 >= MOD_SIZE'(21)) ? x2 - MOD_SIZE'(21) : x2;
                    x3_d  = (x3 >= MOD_SIZE'(5)) ? x3 - MOD_SIZE'(5) : x3;
                    err_d = 1'b0;
`endif
                    state_d = StD2;
                end
            end
            StD2: begin
                t1      = (10'(x1_q) + 10'd62 - 10'(a1_q)) % 10'd31;
                a2_d    = MOD_SIZE'(t1);
                state_d = StD3;
            end
            StD3: begin
                t1      = (10'(x2_q) + 10'd42 - 10'(a1_q)) % 10'd21;
                t2      = (t1 * 10'd2 + 10'd42 - 10'(a2_q)) % 10'd21;
                t3      = (t2 * 10'd19) % 10'd21;
                a3_d    = MOD_SIZE'(t3);
                state_d = StD4;
            end
            StD4: begin
                t1      = (10'(x3_q) + 10'd35 - 10'(a1_q)) % 10'd5;
                t2      = (t1 * 10'd3 + 10'd55 - 10'(a2_q) - 10'(a3_q)) % 10'd5;
                a4_d    = 3'(t2);
                state_d = StAcc;
            end
            StAcc: begin
                n_d = DYN_SIZE'(a1_q) + DYN_SIZE'(a2_q) * W2 + DYN_SIZE'(a3_q) * W3 +
                      DYN_SIZE'(a4_q) * W4;
                if (err_q) n_d = '0;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    err_d       = 1'b0;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign out_valid = out_valid_q;
    assign N         = n_q;
    assign busy      = (state_q != StIdle);
    assign conv_cnt  = cnt_q;
`ifdef RNS_RANGE_CHECK_EN
    assign out_err   = err_q;
`else
    assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rns2bin_mrc_seq.sv
// Scoreboard bench for rns2bin_mrc_seq; expected values come from a brute-force CRT search.
module tb_rns2bin_mrc_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [4:0]  x0 = '0, x1 = '0, x2 = '0, x3 = '0;
    logic        in_ready, out_valid, out_err, busy;
    logic [16:0] N;
    logic [7:0]  conv_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;
    logic [17:0] sb_q[$];

    rns2bin_mrc_seq #(.MOD_SIZE(5), .DYN_SIZE(17), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .out_valid(out_valid), .out_ready(out_ready),
        .N(N), .out_err(out_err), .busy(busy), .conv_cnt(conv_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Returns {err, N}.
    function automatic logic [17:0] model(input int a, input int b, input int c, input int d);
        int n;
`ifdef RNS_RANGE_CHECK_EN
        if (b >= 31 || c >= 21 || d >= 5) return {1'b1, 17'd0};
`else
        if (b == 31) b = 0;
        if (c >= 21) c = c - 21;
        if (d >= 5) d = d - 5;
`endif
        for (int k = 0; k < 3255; k++) begin
            n = a + 32 * k;
            if (n % 31 == b && n % 21 == c && n % 5 == d) return {1'b0, 17'(n)};
        end
        return {1'b1, 17'h1ffff};
    endfunction

    task automatic drive(input logic [4:0] a, b, c, d, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; x0 = a; x1 = b; x2 = c; x3 = d;
        for (int i = 0; i < 60; i++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                sb_q.push_back(model(a, b, c, d));
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_ovalid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (N !== 17'd0) $display("FAIL rst_N got %0d want 0", N); else n_pass++;
        n_checks++; if (conv_cnt !== 8'd0) $display("FAIL rst_cnt got %0d want 0", conv_cnt); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_inready got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_err !== 1'b0) $display("FAIL rst_err got %b want 0", out_err); else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [4:0]  t[4][4] = '{'{0, 0, 0, 0}, '{8, 8, 13, 0}, '{25, 7, 18, 0}, '{31, 30, 20, 4}};
        logic [16:0] k[4] = '{17'd0, 17'd1000, 17'd12345, 17'd104159};
        logic [17:0] e;
        bit ok;
        int cyc;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(t[i][0], t[i][1], t[i][2], t[i][3], ok);
            n_checks++; if (!ok) $display("FAIL basic_accept got 0 want 1"); else n_pass++;
            wait_out(cyc);
            n_checks++; if (cyc != 5) $display("FAIL basic_latency got %0d want 5", cyc); else n_pass++;
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 18'h3ffff;
            n_checks++; if (N !== e[16:0]) $display("FAIL basic_N got %0d want %0d", N, e[16:0]); else n_pass++;
            n_checks++; if (N !== k[i]) $display("FAIL basic_Nconst got %0d want %0d", N, k[i]); else n_pass++;
            n_checks++; if (out_err !== e[17]) $display("FAIL basic_err got %b want %b", out_err, e[17]); else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (dut.a2_q !== 5'd0 || dut.a3_q !== 5'd1 || dut.a4_q !== 3'd0)
                    $display("FAIL basic_digits got %0d/%0d/%0d want 0/1/0", dut.a2_q, dut.a3_q, dut.a4_q);
                else n_pass++;
            end
            @(posedge clk); #1; exp_cnt++;
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_ovalid_clr got %b want 0", out_valid); else n_pass++;
            n_checks++; if (conv_cnt !== 8'(exp_cnt)) $display("FAIL basic_cnt got %0d want %0d", conv_cnt, exp_cnt); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] e;
        bit ok;
        int cyc;
        out_ready = 1'b0;
        drive(5'd25, 5'd7, 5'd18, 5'd0, ok);
        wait_out(cyc);
        n_checks++; if (cyc != 5) $display("FAIL bp_latency got %0d want 5", cyc); else n_pass++;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 18'h3ffff;
        in_valid = 1'b1; x0 = 5'd8; x1 = 5'd8; x2 = 5'd13; x3 = 5'd0;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (N !== e[16:0] || N !== 17'd12345) $display("FAIL bp_hold_N got %0d want 12345", N); else n_pass++;
            n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL bp_hold_hs got ir=%b ov=%b want 0/1", in_ready, out_valid); else n_pass++;
            @(negedge clk);
        end
        n_checks++; if (conv_cnt !== 8'(exp_cnt)) $display("FAIL bp_cnt_hold got %0d want %0d", conv_cnt, exp_cnt); else n_pass++;
        out_ready = 1'b1;
        @(posedge clk); #1; exp_cnt++;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_idle_ready got %b want 1", in_ready); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0; x0 = 5'd31; x1 = 5'd31; x2 = 5'd31; x3 = 5'd7;
        sb_q.push_back(model(8, 8, 13, 0));
        wait_out(cyc);
        n_checks++; if (cyc != 5) $display("FAIL bp_second_latency got %0d want 5", cyc); else n_pass++;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 18'h3ffff;
        n_checks++; if (N !== e[16:0] || N !== 17'd1000) $display("FAIL bp_second_N got %0d want 1000", N); else n_pass++;
        @(posedge clk); #1; exp_cnt++;
    endtask

    task automatic test_reset_midconv();
        logic [17:0] e;
        bit ok, seen;
        int cyc;
        drive(5'd25, 5'd7, 5'd18, 5'd0, ok);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before got %b want 1", busy); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL mid_rst_state got busy=%b ov=%b want 0/0", busy, out_valid); else n_pass++;
        n_checks++; if (N !== 17'd0 || conv_cnt !== 8'd0) $display("FAIL mid_rst_regs got N=%0d cnt=%0d want 0/0", N, conv_cnt); else n_pass++;
        void'(sb_q.pop_back());
        exp_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen) $display("FAIL mid_no_result got 1 want 0"); else n_pass++;
        drive(5'd31, 5'd30, 5'd20, 5'd4, ok);
        wait_out(cyc);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 18'h3ffff;
        n_checks++; if (N !== e[16:0] || N !== 17'd104159) $display("FAIL mid_after_N got %0d want 104159", N); else n_pass++;
        @(posedge clk); #1; exp_cnt++;
        @(negedge clk);
        n_checks++; if (conv_cnt !== 8'(exp_cnt)) $display("FAIL mid_after_cnt got %0d want %0d", conv_cnt, exp_cnt); else n_pass++;
    endtask

    task automatic test_range();
        logic [17:0] e;
        bit ok;
        int cyc;
        drive(5'd0, 5'd0, 5'd25, 5'd0, ok);
        wait_out(cyc);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 18'h3ffff;
        n_checks++; if (N !== e[16:0] || out_err !== e[17]) $display("FAIL range_model got N=%0d err=%b want N=%0d err=%b", N, out_err, e[16:0], e[17]); else n_pass++;
`ifdef RNS_RANGE_CHECK_EN
        n_checks++; if (N !== 17'd0 || out_err !== 1'b1) $display("FAIL range_flag got N=%0d err=%b want 0/1", N, out_err); else n_pass++;
`else
        // Canonicalised to (0,0,4,0).
        n_checks++; if (N !== 17'd4960 || out_err !== 1'b0) $display("FAIL range_canon got N=%0d err=%b want 4960/0", N, out_err); else n_pass++;
`endif
        @(posedge clk); #1; exp_cnt++;
        @(negedge clk);
        n_checks++; if (out_err !== 1'b0) $display("FAIL range_err_clr got %b want 0", out_err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] t[8][4];
        for (int i = 0; i < 8; i++) begin
            t[i][0] = 5'($urandom_range(31));
            t[i][1] = 5'($urandom_range(30));
            t[i][2] = 5'($urandom_range(20));
            t[i][3] = 5'($urandom_range(4));
        end
        out_ready = 1'b1;
        fork
            begin
                bit ok;
                for (int i = 0; i < 8; i++) begin
                    drive(t[i][0], t[i][1], t[i][2], t[i][3], ok);
                    n_checks++; if (!ok) $display("FAIL b2b_accept got 0 want 1"); else n_pass++;
                end
            end
            begin
                int cyc;
                logic [17:0] e;
                for (int j = 0; j < 8; j++) begin
                    wait_out(cyc);
                    e = (sb_q.size() > 0) ? sb_q.pop_front() : 18'h3ffff;
                    n_checks++; if (cyc < 0 || N !== e[16:0]) $display("FAIL b2b_N got %0d want %0d", N, e[16:0]); else n_pass++;
                    @(posedge clk); #1; exp_cnt++;
                end
            end
        join
        @(negedge clk);
        n_checks++; if (conv_cnt !== 8'(exp_cnt)) $display("FAIL b2b_cnt got %0d want %0d", conv_cnt, exp_cnt); else n_pass++;
    endtask

    task automatic test_saturate();
        bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) drive(5'(i), 5'd1, 5'd2, 5'd3, ok);
        repeat (10) @(negedge clk);
        sb_q.delete();
        n_checks++; if (conv_cnt !== 8'hff) $display("FAIL sat_cnt got %0d want 255", conv_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_midconv();
        test_range();
        test_back_to_back();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
